load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Core-side initiator for the byte-addressable data memory. Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-aligned full-word memory reads and writes.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned, illegal-funct3 and out-of-range accesses.
- Sits between the execute stage and the data memory; the core stalls while op_ready is low.

Parameters:
MEM_BYTES, 2048, data memory size in bytes; word address must be <= MEM_BYTES-4

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  core presents an access; sampled only when op_ready=1
op_store  input  1  1=store, 0=load
op_funct3  input  3  RV32I funct3 (load 000/001/010/100/101, store 000/001/010)
op_addr  input  32  byte address
op_wdata  input  32  store data (low byte/half used for SB/SH)
op_ready  output  1  unit idle, can accept
done  output  1  one-cycle completion pulse
err  output  1  valid with done; access rejected, no memory activity
load_data  output  32  extended load result, valid with done, held until next done
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}
mem_wdata  output  32  full word to write
mem_rdata  input  32  memory read data; valid the cycle after mem_read=1

Behaviour:
- Reset: asynchronous active-low (rst_n), one clock (clk). All outputs registered; on reset: state IDLE, op_ready=1, done=0, err=0, load_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: return to IDLE immediately. mem_write drops asynchronously, so no write occurs if rst_n is low at the clock edge. The pending op is discarded with no done.
- Accept: in IDLE with op_valid=1, latch funct3, addr, wdata and op_store; op_ready falls the next cycle.
- Error check at accept. err if any of:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - illegal funct3
  - word address > MEM_BYTES-4
- Error path: IDLE->DONE with err=1, load_data unchanged, no mem_read/mem_write ever asserted.
- States: IDLE, RD, CAPT, WR, DONE.
- Load: IDLE->RD (mem_read=1) ->CAPT (sample mem_rdata, extract lane, register load_data) ->DONE (done=1) ->IDLE.
- Load extraction: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Load latency: done is high 3 cycles after the accept cycle.
- SW: IDLE->WR (mem_write=1, mem_wdata=op_wdata) ->DONE->IDLE. done 2 cycles after accept.
- SB/SH: IDLE->RD->CAPT (merge op_wdata low byte/half into mem_rdata at the lane, others preserved) ->WR->DONE->IDLE. done 4 cycles after accept.
- mem_read and mem_write are never high together. Each is high for exactly one cycle per access. mem_addr is stable from RD/WR entry through DONE.
- done/err are high only in DONE, for exactly one cycle.
- op_ready=1 only in IDLE. The next op can be accepted the cycle after DONE. op_valid while busy is ignored.

Test Plan:
- Memory word 0x100=0x8899AABB:
  - LB 0x101 -> load_data 0xFFFFFFAA
  - LBU 0x102 -> 0x00000099
  - LH 0x102 -> 0xFFFF8899
  - LHU 0x100 -> 0x0000AABB
  - each done exactly 3 cycles after accept, err=0
- SB 0x103 wdata 0x12345677 -> one mem_read at 0x100, then one mem_write 0x100 wdata 0x7799AABB; subsequent LW 0x100 -> 0x7799AABB.
- SW 0x200 wdata 0xDEADBEEF -> single mem_write, no mem_read, done 2 cycles after accept; LW 0x200 -> 0xDEADBEEF.
- Error cases, each giving done=1 err=1 one cycle after accept, zero mem_read/mem_write:
  - SH 0x101
  - LW 0x202
  - LW 0x800 (MEM_BYTES=2048)
  - load funct3=011
- Reset pulse during CAPT of SB 0x104 -> mem_write never asserted, memory word unchanged, outputs at reset values immediately, op_ready=1 after release.
- Back-to-back: op_valid held high with LW 0x0 then LW 0x4 -> second accepted the cycle after first done; op_valid during busy ignored (no extra done).

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word loads and stores into
// word-aligned full-word memory reads and writes, with sign/zero extension
// on loads, read-modify-write on sub-word stores, and access error checking.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic        op_store,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MAX_WORD_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [2:0] {IDLE, RD, CAPT, WR, DONE} state_t;

    state_t      state;
    logic        st_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    // Rejects illegal funct3, misaligned half/word and out-of-range accesses.
    function automatic logic access_err(input logic st, input logic [2:0] f,
                                        input logic [31:0] a);
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = st ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
        misal  = ((f[1:0] == 2'b01) && a[0]) ||
                 ((f[1:0] == 2'b10) && (a[1:0] != 2'b00));
        oor    = {a[31:2], 2'b00} > MAX_WORD_ADDR;
        return bad_f3 | misal | oor;
    endfunction

    // Selects the addressed lane of the read word and extends it.
    function automatic logic [31:0] load_extract(input logic [2:0] f,
                                                 input logic [1:0] lane,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    // Merges the store byte/half into the old word, other lanes preserved.
    function automatic logic [31:0] store_merge(input logic [2:0] f,
                                                input logic [1:0] lane,
                                                input logic [31:0] old,
                                                input logic [15:0] wd);
        logic [31:0] r;
        r = old;
        if (f == 3'b000) r[{lane, 3'b000} +: 8] = wd[7:0];
        else             r[{lane[1], 4'b0000} +: 16] = wd;
        return r;
    endfunction

    // Access sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_ready  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            st_q      <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            wdata_q   <= 16'h0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        st_q     <= op_store;
                        f3_q     <= op_funct3;
                        lane_q   <= op_addr[1:0];
                        wdata_q  <= op_wdata[15:0];
                        op_ready <= 1'b0;
                        if (access_err(op_store, op_funct3, op_addr)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            mem_addr <= {op_addr[31:2], 2'b00};
                            if (op_store && op_funct3 == 3'b010) begin
                                state     <= WR;
                                mem_write <= 1'b1;
                                mem_wdata <= op_wdata;
                            end else begin
                                state    <= RD;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                RD: state <= CAPT;
                CAPT: begin
                    if (st_q) begin
                        mem_wdata <= store_merge(f3_q, lane_q, mem_rdata, wdata_q);
                        mem_write <= 1'b1;
                        state     <= WR;
                    end else begin
                        load_data <= load_extract(f3_q, lane_q, mem_rdata);
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                WR: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-array memory, reference memory model,
// per-cycle compare process and directed access sequence.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 2048;
    localparam int unsigned WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic        op_store;
    logic [2:0]  op_funct3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_ready;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_store  (op_store),
        .op_funct3 (op_funct3),
        .op_addr   (op_addr),
        .op_wdata  (op_wdata),
        .op_ready  (op_ready),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h11223344;
            1:       return 32'h55667788;
            64:      return 32'h8899AABB;
            65:      return 32'hCAFEF00D;
            511:     return 32'h0BADF00D;
            default: return (32'(i) * 32'h00010001) ^ 32'h5A5A0000;
        endcase
    endfunction

    // Memory environment: read data one cycle after mem_read.
    logic [31:0] mem [WORDS];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < int'(WORDS); i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_read)  mem_rdata <= mem[mem_addr[10:2]];
            if (mem_write) mem[mem_addr[10:2]] <= mem_wdata;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    logic [31:0] last_ld;

    function automatic logic model_err(input logic st, input logic [2:0] f, input logic [31:0] a);
        logic bad, mis, oor;
        bad = st ? (f > 3'd2) : (f == 3'd3 || f > 3'd5);
        mis = ((f == 3'd1 || f == 3'd5) && (a % 2) != 0) || (f == 3'd2 && (a % 4) != 0);
        oor = (a - (a % 4)) > 32'(MEM_BYTES - 4);
        return bad || mis || oor;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
        logic [31:0] w, b, h;
        w = ref_mem[a / 4];
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (f)
            3'd0:    return (b >= 32'd128) ? b | 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32'd32768) ? h | 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f, input logic [31:0] a,
                                                input logic [31:0] wd);
        logic [31:0] w, mask, sh;
        w = ref_mem[a / 4];
        if (f == 3'd2) return wd;
        if (f == 3'd0) begin
            sh   = 8 * (a % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end
        sh   = 16 * ((a % 4) / 2);
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    endfunction

    // Expectations for the in-flight access
    bit          exp_pending = 1'b0;
    bit          seen_done = 1'b0;
    int          exp_done_cyc = 0;
    logic        exp_err;
    logic [31:0] exp_ld;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    int          exp_nrd, exp_nwr;
    int          nrd = 0;
    int          nwr = 0;

    // Per-cycle compare against the model's expectations.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mem_read || mem_write) begin
                chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
                chk("mem_addr", mem_addr, exp_addr);
            end
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_pending && cyc == exp_done_cyc) begin
                chk("done", 32'(done), 32'h1);
                chk("err", 32'(err), 32'(exp_err));
                chk("load_data", load_data, exp_ld);
                chk("n_mem_read", 32'(nrd), 32'(exp_nrd));
                chk("n_mem_write", 32'(nwr), 32'(exp_nwr));
                chk("op_ready_busy", 32'(op_ready), 32'h0);
                exp_pending = 1'b0;
                seen_done   = 1'b1;
            end else if (done) begin
                chk("spurious_done", 32'(done), 32'h0);
            end
        end
    end

    // Issues one access at the next idle cycle and waits for its completion.
    task automatic issue(input logic st, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold);
        int n;
        logic e;
        int lat;
        logic [31:0] nw;
        n = 0;
        while (!op_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!op_ready) chk("ready_timeout", 32'(op_ready), 32'h1);
        e   = model_err(st, f, a);
        lat = e ? 1 : (!st ? 3 : (f == 3'd2 ? 2 : 4));
        nw  = 32'h0;
        if (!e && st) nw = model_store(f, a, wd);
        if (!e && !st) last_ld = model_load(f, a);
        exp_addr     = a & ~32'h3;
        exp_wdata    = nw;
        exp_ld       = last_ld;
        exp_err      = e;
        exp_nrd      = (!e && (!st || f != 3'd2)) ? 1 : 0;
        exp_nwr      = (!e && st) ? 1 : 0;
        nrd          = 0;
        nwr          = 0;
        seen_done    = 1'b0;
        exp_done_cyc = cyc + lat;
        exp_pending  = 1'b1;
        op_valid  = 1'b1;
        op_store  = st;
        op_funct3 = f;
        op_addr   = a;
        op_wdata  = wd;
        @(posedge clk); #2;
        if (!hold) op_valid = 1'b0;
        n = 0;
        while (!seen_done && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (!seen_done) begin
            chk("done_timeout", 32'(seen_done), 32'h1);
            exp_pending = 1'b0;
        end
        if (!e && st) ref_mem[a / 4] = nw;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_ready"}, 32'(op_ready), 32'h1);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
        chk({tag, "_load_data"}, load_data, 32'h0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
        last_ld   = 32'h0;
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_store  = 1'b0;
        op_funct3 = 3'b000;
        op_addr   = 32'h0;
        op_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;

        // Loads from word 0x100 = 0x8899AABB
        issue(1'b0, 3'd0, 32'h101, 32'h0, 1'b0);
        chk("lit_lb_101", load_data, 32'hFFFFFFAA);
        issue(1'b0, 3'd4, 32'h102, 32'h0, 1'b0);
        chk("lit_lbu_102", load_data, 32'h00000099);
        issue(1'b0, 3'd1, 32'h102, 32'h0, 1'b0);
        chk("lit_lh_102", load_data, 32'hFFFF8899);
        issue(1'b0, 3'd5, 32'h100, 32'h0, 1'b0);
        chk("lit_lhu_100", load_data, 32'h0000AABB);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);

        // Sub-word and word stores
        issue(1'b1, 3'd0, 32'h103, 32'h12345677, 1'b0);
        chk("lit_sb_mem", mem[64], 32'h7799AABB);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
        chk("lit_lw_100", load_data, 32'h7799AABB);
        issue(1'b1, 3'd2, 32'h200, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 3'd2, 32'h200, 32'h0, 1'b0);
        chk("lit_lw_200", load_data, 32'hDEADBEEF);

        // Rejected accesses
        issue(1'b1, 3'd1, 32'h101, 32'h5555, 1'b0);
        issue(1'b0, 3'd2, 32'h202, 32'h0, 1'b0);
        issue(1'b0, 3'd2, 32'h800, 32'h0, 1'b0);
        issue(1'b0, 3'd3, 32'h100, 32'h0, 1'b0);
        chk("lit_err_ld_held", load_data, 32'hDEADBEEF);
        issue(1'b1, 3'd3, 32'h100, 32'h0, 1'b0);
        issue(1'b0, 3'd5, 32'h7FD, 32'h0, 1'b0);

        // Top word of memory is legal
        issue(1'b0, 3'd2, 32'h7FC, 32'h0, 1'b0);
        issue(1'b0, 3'd1, 32'h7FE, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h7FC, 32'h13579BDF, 1'b0);
        issue(1'b0, 3'd2, 32'h7FC, 32'h0, 1'b0);
        issue(1'b0, 3'd0, 32'h7FF, 32'h0, 1'b0);

        // Reset in the CAPT cycle of SB 0x104
        exp_addr  = 32'h104;
        nrd       = 0;
        nwr       = 0;
        op_valid  = 1'b1;
        op_store  = 1'b1;
        op_funct3 = 3'd0;
        op_addr   = 32'h104;
        op_wdata  = 32'hA5A5A5A5;
        @(posedge clk); #2;
        op_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        last_ld = 32'h0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        chk("midrst_ready_after", 32'(op_ready), 32'h1);
        chk("midrst_no_write", 32'(nwr), 32'h0);
        chk("midrst_mem_kept", mem[65], ref_mem[65]);

        // Store into the same word after the aborted one
        issue(1'b1, 3'd1, 32'h106, 32'h0000BEEF, 1'b0);
        issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b0);

        // Back-to-back with op_valid held through the busy cycles
        issue(1'b0, 3'd2, 32'h0, 32'h0, 1'b1);
        chk("lit_lw_0", load_data, 32'h11223344);
        issue(1'b0, 3'd2, 32'h4, 32'h0, 1'b0);
        chk("lit_lw_4", load_data, 32'h55667788);
        repeat (4) @(posedge clk);
        #2;
        chk("idle_ready", 32'(op_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
